// File: rtl/video_stream_gen.sv
// Raster timing generator with selectable synthetic gray patterns.
// Drives an 8-bit gray pixel stream with hsync, vsync and data-enable.
module video_stream_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CHK_SHIFT = 3
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic [1:0] pattern_sel,
    input  logic [7:0] const_level,
    output logic [7:0] out_gary,
    output logic       out_hsync,
    output logic       out_vsync,
    output logic       out_en,
    output logic       frame_done,
    output logic       busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] H_SS   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SE   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] V_SS   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SE   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    // Counters are 12 bits wide; larger rasters cannot be represented.
    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_check
        $error("video_stream_gen: raster total exceeds 12-bit counters");
    end

    if (CHK_SHIFT < 0 || CHK_SHIFT > 11) begin : g_chk_check
        $error("video_stream_gen: CHK_SHIFT out of counter range");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [11:0] h_cnt, h_n;
    logic [11:0] v_cnt, v_n;
    logic [1:0]  sel_r, sel_n;

    logic        h_end;
    logic        v_end;
    logic        en_d;
    logic        hs_d;
    logic        vs_d;
    logic        fd_d;
    logic [7:0]  gray_d;
    logic        chk_bit;

    assign h_end = (h_cnt == H_LAST);
    assign v_end = (v_cnt == V_LAST);

    // State, raster counters and latched pattern select.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
            sel_r <= '0;
        end else begin
            state <= state_n;
            h_cnt <= h_n;
            v_cnt <= v_n;
            sel_r <= sel_n;
        end
    end

    // Next-state: raster walk in RUN, frame restart or stop at the last position.
    always_comb begin
        state_n = state;
        h_n     = h_cnt;
        v_n     = v_cnt;
        sel_n   = sel_r;
        unique case (state)
            IDLE: begin
                h_n = '0;
                v_n = '0;
                if (start) begin
                    state_n = RUN;
                    sel_n   = pattern_sel;
                end
            end
            RUN: begin
                if (h_end) begin
                    h_n = '0;
                    if (v_end) begin
                        v_n = '0;
                        if (start) begin
                            sel_n = pattern_sel;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        v_n = v_cnt + 12'd1;
                    end
                end else begin
                    h_n = h_cnt + 12'd1;
                end
            end
            default: begin
                state_n = IDLE;
                h_n     = '0;
                v_n     = '0;
            end
        endcase
    end

    assign chk_bit = h_cnt[CHK_SHIFT] ^ v_cnt[CHK_SHIFT];

    // Timing and pattern decode of the current raster position.
    always_comb begin
        en_d   = 1'b0;
        hs_d   = 1'b0;
        vs_d   = 1'b0;
        fd_d   = 1'b0;
        gray_d = 8'h00;
        if (state == RUN) begin
            en_d = (h_cnt < H_ACT) && (v_cnt < V_ACT);
            hs_d = (h_cnt >= H_SS) && (h_cnt < H_SE);
            vs_d = (v_cnt >= V_SS) && (v_cnt < V_SE);
            fd_d = h_end && v_end;
            if (en_d) begin
                unique case (1'b1)
                    (sel_r == 2'd0): gray_d = h_cnt[7:0];
                    (sel_r == 2'd1): gray_d = v_cnt[7:0];
                    (sel_r == 2'd2): gray_d = chk_bit ? 8'hFF : 8'h00;
                    (sel_r == 2'd3): gray_d = const_level;
                    default:         gray_d = 8'h00;
                endcase
            end
        end
    end

    // Output register: stream lags counters by one cycle; busy tracks next state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_gary   <= 8'h00;
            out_hsync  <= 1'b0;
            out_vsync  <= 1'b0;
            out_en     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            out_gary   <= gray_d;
            out_hsync  <= hs_d;
            out_vsync  <= vs_d;
            out_en     <= en_d;
            frame_done <= fd_d;
            busy       <= (state_n == RUN);
        end
    end

endmodule
